// File: rtl/dmem_sram_ctrl_if.sv
// LSU-to-data-memory bus.
// The master (memory stage) drives req/wr/addr/wdata/be and holds them until gnt.
// The slave (dmem_sram_ctrl) answers with gnt. For loads it also returns
// rdata/valid/err RD_LATENCY cycles after the grant.
interface dmem_if;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_err;

  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_be,
    input  data_gnt, data_rdata, data_valid, data_err
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_be,
    output data_gnt, data_rdata, data_valid, data_err
  );
endinterface

// File: rtl/dmem_sram_ctrl.sv
// Data-memory slave terminating the LSU bus.
// - Word-organised, byte-writable SRAM array of DEPTH_WORDS words mapped at BASE_ADDR.
// - Grants a held request after GNT_DELAY wait-states.
// - Stores write the selected byte lanes on the grant edge.
// - Loads read the array on the grant edge and return the full word through an
//   RD_LATENCY-deep response pipeline.
// - Out-of-range stores are dropped. Out-of-range loads return data 0 with data_err.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      dmem_if.slave: data_req/wr/addr/wdata/be in, data_gnt/rdata/valid/err out
module dmem_sram_ctrl #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          GNT_DELAY   = 0,
  parameter int          RD_LATENCY  = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  dmem_if.slave bus
);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          LAST  = RD_LATENCY - 1;
  // 33-bit bound so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  logic                 rdy_q, rdy_d;
  logic [2:0]           wait_cnt_q, wait_cnt_d;
  logic [LAST:0]        vld_pipe_q, vld_pipe_d;
  logic [LAST:0]        err_pipe_q, err_pipe_d;
  logic [LAST:0][31:0]  word_pipe_q, word_pipe_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [3:0][7:0]      mem [DEPTH_WORDS];

  logic                 gnt, in_range, st_en, ld_gnt;
  logic [31:0]          offset;
  logic [IDX_W-1:0]     idx;
  logic                 unused_addr_bits;

  assign in_range = ({1'b0, bus.data_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, bus.data_addr} <  LIMIT);
  assign offset   = bus.data_addr - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  // Byte offset within the word and the bits above the array are decoded by in_range.
  assign unused_addr_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  assign gnt    = rdy_q & bus.data_req & (wait_cnt_q == 3'(GNT_DELAY));
  assign st_en  = gnt & bus.data_wr & in_range;
  assign ld_gnt = gnt & ~bus.data_wr;

  always_comb begin
    rdy_d       = 1'b1;
    wait_cnt_d  = (bus.data_req && !gnt) ? wait_cnt_q + 3'd1 : 3'd0;
    vld_pipe_d  = '0;
    err_pipe_d  = '0;
    word_pipe_d = '0;
    // Stage 1 captures the array read at the grant edge.
    // err is gated by the load grant so data_err stays quiet between responses.
    vld_pipe_d[0]  = ld_gnt;
    err_pipe_d[0]  = ld_gnt & ~in_range;
    word_pipe_d[0] = in_range ? mem[idx] : 32'h0;
    for (int s = 1; s <= LAST; s++) begin
      vld_pipe_d[s]  = vld_pipe_q[s-1];
      err_pipe_d[s]  = err_pipe_q[s-1];
      word_pipe_d[s] = word_pipe_q[s-1];
    end
    // rdata loads in step with the last stage, so it is valid together with data_valid
    // and holds between responses.
    rdata_d = vld_pipe_d[LAST] ? word_pipe_d[LAST] : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q       <= 1'b0;
      wait_cnt_q  <= 3'd0;
      vld_pipe_q  <= '0;
      err_pipe_q  <= '0;
      word_pipe_q <= '0;
      rdata_q     <= 32'h0;
    end else begin
      rdy_q       <= rdy_d;
      wait_cnt_q  <= wait_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      err_pipe_q  <= err_pipe_d;
      word_pipe_q <= word_pipe_d;
      rdata_q     <= rdata_d;
    end
  end

  // Array contents are not reset.
  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be[b]) mem[idx][b] <= bus.data_wdata[8*b +: 8];
      end
    end
  end

  assign bus.data_gnt   = gnt;
  assign bus.data_valid = vld_pipe_q[LAST];
  assign bus.data_err   = err_pipe_q[LAST];
  assign bus.data_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Bench for dmem_sram_ctrl. It builds three instances:
//   inst 0: GNT_DELAY=0, RD_LATENCY=1
//   inst 1: GNT_DELAY=0, RD_LATENCY=3
//   inst 2: GNT_DELAY=3, RD_LATENCY=1
// A byte-level memory model plus a response queue predict gnt/valid/err/rdata every cycle.
// Directed steps also check hand-computed literals.
module tb_dmem_sram_ctrl;
  localparam int          NI    = 3;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] req, wr, gnt, valid, err;
  logic [31:0]   addr  [NI];
  logic [31:0]   wdata [NI];
  logic [3:0]    be    [NI];
  logic [31:0]   rdata [NI];

  for (genvar k = 0; k < NI; k++) begin : g_inst
    dmem_if bus ();
    assign bus.data_req   = req[k];
    assign bus.data_wr    = wr[k];
    assign bus.data_addr  = addr[k];
    assign bus.data_wdata = wdata[k];
    assign bus.data_be    = be[k];
    assign gnt[k]   = bus.data_gnt;
    assign valid[k] = bus.data_valid;
    assign err[k]   = bus.data_err;
    assign rdata[k] = bus.data_rdata;
    dmem_sram_ctrl #(
      .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
      .GNT_DELAY(k == 2 ? 3 : 0), .RD_LATENCY(k == 1 ? 3 : 1)
    ) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int gd(input int k); return (k == 2) ? 3 : 0; endfunction
  function automatic int rl(input int k); return (k == 1) ? 3 : 1; endfunction
  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4*DEPTH));
  endfunction
  function automatic int bkey(input int k, input logic [31:0] a, input int b);
    return k*65536 + int'((a - BASE) & 32'h0000_FFFC) + b;
  endfunction

  typedef struct { int k; int due; bit err; bit known; logic [31:0] word; } rsp_t;
  typedef struct { int k; int e; logic [31:0] d; bit er; } log_t;

  rsp_t        rq [$];
  log_t        lg [$];
  logic [7:0]  mb [int];
  bit          rdy_m [NI];
  int          wc_m [NI];
  bit          v_exp [NI];
  bit          e_exp [NI];
  bit          rd_known [NI];
  logic [31:0] rd_exp [NI];
  int          ecnt = 0;

  // The slave is ready after one edge, then needs req held GNT_DELAY prior cycles.
  function automatic bit exp_gnt(input int k);
    return rdy_m[k] && req[k] && (wc_m[k] == gd(k));
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      rq.delete();
      for (int k = 0; k < NI; k++) begin
        rdy_m[k] = 0; wc_m[k] = 0; v_exp[k] = 0; e_exp[k] = 0;
        rd_exp[k] = '0; rd_known[k] = 1;
      end
    end else begin
      ecnt++;
      for (int k = 0; k < NI; k++) begin
        bit g;
        g = exp_gnt(k);
        if (g && wr[k]) begin
          if (in_rng(addr[k]))
            for (int b = 0; b < 4; b++)
              if (be[k][b]) mb[bkey(k, addr[k], b)] = wdata[k][8*b +: 8];
        end else if (g) begin
          rsp_t r;
          r.k = k; r.due = ecnt + rl(k) - 1; r.err = !in_rng(addr[k]);
          r.word = '0; r.known = 1;
          if (in_rng(addr[k]))
            for (int b = 0; b < 4; b++) begin
              if (mb.exists(bkey(k, addr[k], b))) r.word[8*b +: 8] = mb[bkey(k, addr[k], b)];
              else r.known = 0;
            end
          rq.push_back(r);
        end
        wc_m[k] = (req[k] && !g) ? (wc_m[k] + 1) % 8 : 0;
        rdy_m[k] = 1;
      end
      for (int k = 0; k < NI; k++) v_exp[k] = 0;
      begin
        int i;
        i = 0;
        while (i < rq.size()) begin
          if (rq[i].due == ecnt) begin
            v_exp[rq[i].k]    = 1;
            e_exp[rq[i].k]    = rq[i].err;
            rd_exp[rq[i].k]   = rq[i].word;
            rd_known[rq[i].k] = rq[i].known;
            rq.delete(i);
          end else i++;
        end
      end
    end
  end

  // Compare every cycle and log every response pulse.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("gnt_i%0d_e%0d", k, ecnt), 32'(gnt[k]), 32'(exp_gnt(k)));
      chk($sformatf("valid_i%0d_e%0d", k, ecnt), 32'(valid[k]), 32'(v_exp[k]));
      if (v_exp[k]) chk($sformatf("err_i%0d_e%0d", k, ecnt), 32'(err[k]), 32'(e_exp[k]));
      if (rd_known[k]) chk($sformatf("rdata_i%0d_e%0d", k, ecnt), rdata[k], rd_exp[k]);
      if (valid[k] === 1'b1) lg.push_back('{k, ecnt, rdata[k], err[k]});
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the grant edge.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int waited, output int ge);
    req[k] = 1; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    waited = 0; ge = -1;
    while (ge < 0 && waited <= 20) begin
      @(negedge clk);
      if (gnt[k]) ge = ecnt + 1;
      else waited++;
    end
    chk($sformatf("grant_seen_i%0d", k), 32'(ge >= 0), 32'd1);
    @(posedge clk); #1;
    req[k] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input string nm, input int k, input int e,
                            input logic [31:0] d, input bit er);
    bit found;
    logic [31:0] fd;
    bit fe;
    found = 0; fd = '0; fe = 0;
    foreach (lg[i]) if (lg[i].k == k && lg[i].e == e) begin
      found = 1; fd = lg[i].d; fe = lg[i].er;
    end
    chk({nm, "_valid_at_edge"}, 32'(found), 32'd1);
    if (found) begin
      chk({nm, "_rdata"}, fd, d);
      chk({nm, "_err"}, 32'(fe), 32'(er));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w, ge, ge1, ge2, ge3, rst_e, rel_e, stale;
    for (int k = 0; k < NI; k++) begin
      req[k] = 0; wr[k] = 0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    req[2] = 1; wr[2] = 0; addr[2] = BASE;  // gnt must stay low in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt[2]), 32'd0);
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_err", 32'(err[1]), 32'd0);
    chk("rst_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    req[2] = 0;
    reset_n = 1;
    idle(2);

    // 1: same-cycle grant, one-cycle load latency
    issue(0, 1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, w, ge);
    chk("t1_store_wait", w, 0);
    issue(0, 0, 32'h0001_0010, 32'h0, 4'hF, w, ge);
    chk("t1_load_wait", w, 0);
    idle(3);
    expect_rsp("t1", 0, ge, 32'hDEAD_BEEF, 0);

    // 2: byte-lane merge
    issue(0, 1, 32'h0001_0020, 32'h1122_3344, 4'hF, w, ge);
    issue(0, 1, 32'h0001_0020, 32'hAABB_CCDD, 4'b0100, w, ge);
    issue(0, 1, 32'h0001_0020, 32'hFFFF_FFFF, 4'b0000, w, ge);
    issue(0, 0, 32'h0001_0020, 32'h0, 4'hF, w, ge);
    idle(3);
    expect_rsp("t2", 0, ge, 32'h11BB_3344, 0);

    // 3: GNT_DELAY=3, then a withdrawn store
    issue(2, 1, 32'h0001_0030, 32'h5A5A_5A5A, 4'hF, w, ge);
    chk("t3_wait_cycles", w, 3);
    req[2] = 1; wr[2] = 1; addr[2] = 32'h0001_0030; wdata[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
    @(negedge clk); chk("t3_drop_gnt_c1", 32'(gnt[2]), 32'd0);
    @(negedge clk); chk("t3_drop_gnt_c2", 32'(gnt[2]), 32'd0);
    @(posedge clk); #1;
    req[2] = 0;
    idle(1);
    issue(2, 0, 32'h0001_0030, 32'h0, 4'hF, w, ge);
    chk("t3_wait_after_drop", w, 3);
    idle(3);
    expect_rsp("t3", 2, ge, 32'h5A5A_5A5A, 0);

    // 4: RD_LATENCY=3 back-to-back loads
    issue(1, 1, 32'h0001_0000, 32'hA000_0000, 4'hF, w, ge);
    issue(1, 1, 32'h0001_0004, 32'hA100_0001, 4'hF, w, ge);
    issue(1, 1, 32'h0001_0008, 32'hA200_0002, 4'hF, w, ge);
    issue(1, 0, 32'h0001_0000, 32'h0, 4'hF, w, ge1);
    issue(1, 0, 32'h0001_0004, 32'h0, 4'hF, w, ge2);
    issue(1, 0, 32'h0001_0008, 32'h0, 4'hF, w, ge3);
    chk("t4_b2b_gnt2", ge2 - ge1, 1);
    chk("t4_b2b_gnt3", ge3 - ge1, 2);
    idle(6);
    expect_rsp("t4_r0", 1, ge1 + 2, 32'hA000_0000, 0);
    expect_rsp("t4_r1", 1, ge1 + 3, 32'hA100_0001, 0);
    expect_rsp("t4_r2", 1, ge1 + 4, 32'hA200_0002, 0);

    // 5: range decode
    issue(0, 1, 32'h0001_0000, 32'h0123_4567, 4'hF, w, ge);
    issue(0, 1, 32'h0001_3FFC, 32'hCAFE_F00D, 4'hF, w, ge);
    issue(0, 0, 32'h0000_FFFC, 32'h0, 4'hF, w, ge);
    idle(3);
    expect_rsp("t5_below", 0, ge, 32'h0, 1);
    issue(0, 0, 32'h0001_3FFC, 32'h0, 4'hF, w, ge);
    idle(3);
    expect_rsp("t5_last_word", 0, ge, 32'hCAFE_F00D, 0);
    issue(0, 0, 32'h0001_4000, 32'h0, 4'hF, w, ge);
    idle(3);
    expect_rsp("t5_above", 0, ge, 32'h0, 1);
    issue(0, 1, 32'h0001_4000, 32'hFFFF_FFFF, 4'hF, w, ge);
    issue(0, 0, 32'h0001_0000, 32'h0, 4'hF, w, ge);
    idle(3);
    expect_rsp("t5_oob_store_dropped", 0, ge, 32'h0123_4567, 0);

    // 6: reset with two loads in flight
    issue(1, 0, 32'h0001_0000, 32'h0, 4'hF, w, ge1);
    issue(1, 0, 32'h0001_0004, 32'h0, 4'hF, w, ge2);
    reset_n = 0;
    rst_e = ecnt;
    repeat (3) begin
      @(negedge clk);
      chk("t6_valid_in_reset", 32'(valid[1]), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1;
    rel_e = ecnt;
    issue(2, 0, 32'h0001_0030, 32'h0, 4'hF, w, ge);
    chk("t6_first_grant_edge", ge - rel_e, 4);
    idle(6);
    expect_rsp("t6_mem_kept", 2, ge, 32'h5A5A_5A5A, 0);
    stale = 0;
    foreach (lg[i]) if (lg[i].k == 1 && lg[i].e >= rst_e) stale++;
    chk("t6_no_stale_valid", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
